// File: rtl/ahbl_mem_bridge_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ahbl_mem_bridge_if - AHB-Lite slave side and memory backend side of the bridge. Rev 1.0
// ---------------------------------------------------------------------------
interface ahbl_mem_bridge_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  logic                  ahbls_hready_resp;
  logic                  ahbls_hready;
  logic                  ahbls_hresp;
  logic [W_ADDR-1:0]     ahbls_haddr;
  logic                  ahbls_hwrite;
  logic [1:0]            ahbls_htrans;
  logic [2:0]            ahbls_hsize;
  logic [W_DATA-1:0]     ahbls_hwdata;
  logic [W_DATA-1:0]     ahbls_hrdata;

  logic                  mem_valid;
  logic                  mem_ready;
  logic                  mem_write;
  logic [W_ADDR-1:0]     mem_addr;
  logic [W_DATA-1:0]     mem_wdata;
  logic [W_DATA/8-1:0]   mem_wmask;
  logic                  mem_rvalid;
  logic [W_DATA-1:0]     mem_rdata;

  modport slave (
    output ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
    input  ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize, ahbls_hwdata,
    output mem_valid, mem_write, mem_addr, mem_wdata, mem_wmask,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    input  ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
    output ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize, ahbls_hwdata,
    input  mem_valid, mem_write, mem_addr, mem_wdata, mem_wmask,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/ahbl_mem_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ahbl_mem_bridge - AHB-Lite slave to valid/ready memory with a posted-write buffer.
// AHBL_MEM_BRIDGE_RAW_CHECK_EN: reads bypass buffered writes to other words. Rev 1.0
// ---------------------------------------------------------------------------
module ahbl_mem_bridge #(
  parameter int          W_ADDR      = 32,
  parameter int          W_DATA      = 32,
  parameter int unsigned DEPTH_BYTES = 1 << 23,
  parameter int          WBUF_DEPTH  = 4
) (
  input wire logic          clk,
  input wire logic          rst_n,
  ahbl_mem_bridge_if.slave  bus
);
  localparam int NB    = W_DATA / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam logic [W_ADDR:0] DEPTH_LIM = (W_ADDR+1)'(DEPTH_BYTES);
  localparam logic [PTR_W:0]  FULL_CNT  = (PTR_W+1)'(WBUF_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_RWAIT  = 3'd2,
    ST_RISSUE = 3'd3,
    ST_RDATA  = 3'd4,
    ST_ERR1   = 3'd5,
    ST_ERR2   = 3'd6
  } state_t;

  state_t             state;
  logic               hready_q;
  logic               hresp_q;
  logic [W_DATA-1:0]  hrdata_q;
  logic [W_ADDR-1:0]  addr_q;
  logic [NB-1:0]      mask_q;

  logic [W_ADDR-1:0]  wb_addr [WBUF_DEPTH];
  logic [W_DATA-1:0]  wb_data [WBUF_DEPTH];
  logic [NB-1:0]      wb_mask [WBUF_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic [PTR_W:0]     count_next;
  logic               full;
  logic               empty;
  logic               full_next;
  logic               push;
  logic               pop;
  logic               drain;

  logic               accept;
  logic               dec_err;
  state_t             dec_state;
  logic               dec_hready;
  logic               dec_hresp;
  logic [W_ADDR-1:0]  dec_waddr;
  logic [NB-1:0]      dec_mask;
  logic               rwait_go;

  function automatic logic [NB-1:0] byte_mask(input logic [2:0] size, input logic [OFF_W-1:0] off);
    int unsigned lo;
    int unsigned hi;
    byte_mask = '0;
    lo = 32'(off);
    hi = lo + (32'd1 << size);
    for (int unsigned b = 0; b < NB; b++) begin
      byte_mask[b] = (b >= lo) && (b < hi);
    end
  endfunction

  // Address-phase decode; only consumed in states where hready_resp is high.
  always_comb begin
    accept     = bus.ahbls_htrans[1] && bus.ahbls_hready;
    dec_err    = ({1'b0, bus.ahbls_haddr} >= DEPTH_LIM) || (int'(bus.ahbls_hsize) > OFF_W);
    dec_waddr  = {bus.ahbls_haddr[W_ADDR-1:OFF_W], {OFF_W{1'b0}}};
    dec_mask   = byte_mask(bus.ahbls_hsize, bus.ahbls_haddr[OFF_W-1:0]);
    dec_state  = ST_IDLE;
    if (accept) begin
      if (dec_err)
        dec_state = ST_ERR1;
      else if (bus.ahbls_hwrite)
        dec_state = ST_WDATA;
      else
        dec_state = ST_RWAIT;
    end
    dec_hready = 1'b1;
    dec_hresp  = 1'b0;
    case (dec_state)
      ST_WDATA: dec_hready = !full_next;
      ST_RWAIT: dec_hready = 1'b0;
      ST_ERR1: begin
        dec_hready = 1'b0;
        dec_hresp  = 1'b1;
      end
      default: ;
    endcase
  end

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign push      = (state == ST_WDATA) && !full;
  assign drain     = !empty && (state != ST_RISSUE) && (state != ST_RDATA);
  assign pop       = drain && bus.mem_ready;
  assign full_next = (count_next == FULL_CNT);

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
  end

`ifdef AHBL_MEM_BRIDGE_RAW_CHECK_EN
  logic             raw_hit;
  logic [PTR_W-1:0] raw_rel;

  // An entry is live when its distance from the head is below the fill count.
  always_comb begin
    raw_hit = 1'b0;
    raw_rel = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      raw_rel = PTR_W'(i) - rd_ptr;
      if (({1'b0, raw_rel} < count) && (wb_addr[i] == addr_q))
        raw_hit = 1'b1;
    end
  end

  assign rwait_go = empty || !raw_hit;
`else
  assign rwait_go = empty;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[wr_ptr] <= addr_q;
      wb_data[wr_ptr] <= bus.ahbls_hwdata;
      wb_mask[wr_ptr] <= mask_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      hrdata_q <= '0;
      addr_q   <= '0;
      mask_q   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_ERR2: begin
          state    <= dec_state;
          hready_q <= dec_hready;
          hresp_q  <= dec_hresp;
        end
        ST_WDATA: begin
          if (!full) begin
            state    <= dec_state;
            hready_q <= dec_hready;
            hresp_q  <= dec_hresp;
          end else begin
            hready_q <= !full_next;
          end
        end
        ST_RWAIT: begin
          if (rwait_go)
            state <= ST_RISSUE;
        end
        ST_RISSUE: begin
          if (bus.mem_ready)
            state <= ST_RDATA;
        end
        ST_RDATA: begin
          if (bus.mem_rvalid) begin
            hrdata_q <= bus.mem_rdata;
            hready_q <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        ST_ERR1: begin
          state    <= ST_ERR2;
          hready_q <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
        end
      endcase
      if (accept) begin
        addr_q <= dec_waddr;
        mask_q <= dec_mask;
      end
    end
  end

  assign bus.ahbls_hready_resp = hready_q;
  assign bus.ahbls_hresp       = hresp_q;
  assign bus.ahbls_hrdata      = hrdata_q;

  // Buffered writes own the backend except while a read is being issued or awaited.
  always_comb begin
    bus.mem_valid = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;
    if (drain) begin
      bus.mem_valid = 1'b1;
      bus.mem_write = 1'b1;
      bus.mem_addr  = wb_addr[rd_ptr];
      bus.mem_wdata = wb_data[rd_ptr];
      bus.mem_wmask = wb_mask[rd_ptr];
    end else if (state == ST_RISSUE) begin
      bus.mem_valid = 1'b1;
      bus.mem_addr  = addr_q;
    end
  end
endmodule
`default_nettype wire
